// File: rtl/picoram_mem_arbiter.sv
// rtl/picoram_mem_arbiter.sv - two-master arbiter for the picoram single-port SRAM
//
// Purpose: shares one single-port SRAM (1-cycle registered read) between two
// PicoRV32-native requesters. m0 (CPU) has fixed priority; m1 (boot loader /
// DMA) is forced through after MAX_STALL consecutive m0 grants while it waits.
// Every transfer walks IDLE -> ISSUE -> RESP, so it occupies at least 3 cycles.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   mN_valid/ready               request / one-cycle completion pulse
//   mN_addr/wdata/wstrb          byte address, write data, byte enables (0 = read)
//   mN_rdata                     read data, valid while mN_ready=1
//   ram_en/we/addr/wdata/rdata   SRAM macro interface (word addressed)
//   grant                        one-hot owner (bit0 = m0), 0 when idle
//   stat_clr, stat_m0, stat_m1, stat_conflict
//                                transfer/conflict counters, only with RAM_ARB_STATS_EN
//
// Optional feature macro: RAM_ARB_STATS_EN

module picoram_mem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int MAX_STALL = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [31:0]       m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wstrb,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [31:0]       m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wstrb,
  output logic [31:0]       m1_rdata,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [1:0]        grant
`ifdef RAM_ARB_STATS_EN
  , input  logic            stat_clr
  , output logic [15:0]     stat_m0
  , output logic [15:0]     stat_m1
  , output logic [15:0]     stat_conflict
`endif
);

  localparam logic [3:0] MAX_STALL_C = 4'(MAX_STALL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [3:0] stall_q, stall_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      grant_q <= 2'b00;
      stall_q <= 4'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    stall_d = stall_q;
    case (state_q)
      S_IDLE: begin
        if (m0_valid || m1_valid) begin
          // m0 keeps priority unless m1 has already been passed over MAX_STALL times.
          if (m0_valid && !(m1_valid && (stall_q == MAX_STALL_C))) begin
            grant_d = 2'b01;
            if (m1_valid) begin
              stall_d = (stall_q >= MAX_STALL_C) ? MAX_STALL_C : stall_q + 4'd1;
            end else begin
              stall_d = 4'd0;
            end
          end else begin
            grant_d = 2'b10;
            stall_d = 4'd0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  // The RAM side is steered purely by the registered grant; requesters hold
  // their address/data until ready, so these are stable through ISSUE.
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_wstrb;

  always_comb begin
    sel_addr  = grant_q[1] ? m1_addr  : m0_addr;
    sel_wdata = grant_q[1] ? m1_wdata : m0_wdata;
    sel_wstrb = grant_q[1] ? m1_wstrb : m0_wstrb;
  end

  assign ram_en    = (state_q == S_ISSUE);
  assign ram_we    = (state_q == S_ISSUE) ? sel_wstrb : 4'b0000;
  assign ram_addr  = sel_addr[ADDR_W+1:2];
  assign ram_wdata = sel_wdata;
  assign grant     = grant_q;

  // RAM read data arrives the cycle after ram_en, which is exactly RESP.
  assign m0_ready  = (state_q == S_RESP) && grant_q[0];
  assign m1_ready  = (state_q == S_RESP) && grant_q[1];
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

  // Address bits outside the word index are intentionally ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

`ifdef RAM_ARB_STATS_EN
  logic [15:0] stat_m0_q, stat_m1_q, stat_conflict_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_m0_q       <= 16'd0;
      stat_m1_q       <= 16'd0;
      stat_conflict_q <= 16'd0;
    end else if (stat_clr) begin
      stat_m0_q       <= 16'd0;
      stat_m1_q       <= 16'd0;
      stat_conflict_q <= 16'd0;
    end else begin
      if (m0_ready) stat_m0_q <= stat_m0_q + 16'd1;
      if (m1_ready) stat_m1_q <= stat_m1_q + 16'd1;
      if ((state_q == S_IDLE) && m0_valid && m1_valid) begin
        stat_conflict_q <= stat_conflict_q + 16'd1;
      end
    end
  end

  assign stat_m0       = stat_m0_q;
  assign stat_m1       = stat_m1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule
